// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//    Free-running VGA raster timing generator. A horizontal/vertical position
//    counter advances once per enabled pixel edge and every output is a
//    registered decode of the position the counter moves to, so x/y and the
//    sync/active flags always line up with no extra latency.
//
// Ports:
//    clk          in   system clock, all state changes on its rising edge
//    rst          in   asynchronous active-high reset
//    pix_en       in   pixel-rate clock enable
//    hsync        out  horizontal sync, pulse level set by HPOL
//    vsync        out  vertical sync, pulse level set by VPOL
//    active       out  1 while the position is inside the visible area
//    x            out  horizontal position, 0..H_TOTAL-1
//    y            out  vertical position, 0..V_TOTAL-1
//    line_start   out  one-clk strobe when x becomes 0
//    frame_start  out  one-clk strobe when (x,y) becomes (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HPOL     = 0,
   parameter int VPOL     = 0,
   parameter int XW       = 11,
   parameter int YW       = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_en,
   output logic          hsync,
   output logic          vsync,
   output logic          active,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [XW-1:0] H_LAST       = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] H_VISIBLE    = XW'(H_ACTIVE);
   localparam logic [XW-1:0] H_SYNC_FIRST = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] H_SYNC_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);

   localparam logic [YW-1:0] V_LAST       = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] V_VISIBLE    = YW'(V_ACTIVE);
   localparam logic [YW-1:0] V_SYNC_FIRST = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] V_SYNC_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

   // Idle (non-pulse) levels of the sync outputs.
   localparam logic H_IDLE = (HPOL != 0);
   localparam logic V_IDLE = (VPOL != 0);

   // Internal position. It parks at the last pixel of the frame during reset
   // so the first enabled edge afterwards lands on (0,0), while the visible
   // x/y outputs already read 0.
   logic [XW-1:0] h_pos_reg;
   logic [YW-1:0] v_pos_reg;
   logic [XW-1:0] h_pos_next;
   logic [YW-1:0] v_pos_next;

   logic hsync_next;
   logic vsync_next;
   logic active_next;

   always_comb begin
      h_pos_next = h_pos_reg + 1'b1;
      v_pos_next = v_pos_reg;
      if (h_pos_reg == H_LAST) begin
         h_pos_next = '0;
         if (v_pos_reg == V_LAST) begin
            v_pos_next = '0;
         end else begin
            v_pos_next = v_pos_reg + 1'b1;
         end
      end
   end

   // Decode the position being entered, so the registered flags match the
   // registered x/y in the same cycle.
   always_comb begin
      hsync_next  = H_IDLE;
      vsync_next  = V_IDLE;
      active_next = (h_pos_next < H_VISIBLE) && (v_pos_next < V_VISIBLE);
      if ((h_pos_next >= H_SYNC_FIRST) && (h_pos_next <= H_SYNC_LAST)) begin
         hsync_next = ~H_IDLE;
      end
      // vsync spans whole lines, horizontal blanking included.
      if ((v_pos_next >= V_SYNC_FIRST) && (v_pos_next <= V_SYNC_LAST)) begin
         vsync_next = ~V_IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_pos_reg   <= H_LAST;
         v_pos_reg   <= V_LAST;
         x           <= '0;
         y           <= '0;
         hsync       <= H_IDLE;
         vsync       <= V_IDLE;
         active      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         // Strobes fall back to 0 on every clk that is not an enabled
         // wrap edge, however long pix_en stays low.
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (pix_en) begin
            h_pos_reg   <= h_pos_next;
            v_pos_reg   <= v_pos_next;
            x           <= h_pos_next;
            y           <= v_pos_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            active      <= active_next;
            line_start  <= (h_pos_next == '0);
            frame_start <= (h_pos_next == '0) && (v_pos_next == '0);
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Bench for vga_timing_gen with an 8-pixel line (4/1/2/1) and a 6-line frame
// (3/1/1/1). Two instances share the stimulus: one with active-high syncs and
// one with inverted sync polarity. Expected values come from a hand-written
// vector table and from an arithmetic model that derives the raster position
// from the number of enabled edges since reset.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int XW = 4;
   localparam int YW = 3;
   localparam int HT = 8;
   localparam int VT = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pix_en = 1'b0;

   logic          hs0, vs0, act0, ls0, fs0;
   logic          hs1, vs1, act1, ls1, fs1;
   logic [XW-1:0] x0, x1;
   logic [YW-1:0] y0, y1;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HPOL(0), .VPOL(0), .XW(XW), .YW(YW)
   ) dut0 (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .hsync(hs0), .vsync(vs0), .active(act0), .x(x0), .y(y0),
      .line_start(ls0), .frame_start(fs0)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HPOL(1), .VPOL(1), .XW(XW), .YW(YW)
   ) dut1 (
      .clk(clk), .rst(rst), .pix_en(pix_en),
      .hsync(hs1), .vsync(vs1), .active(act1), .x(x1), .y(y1),
      .line_start(ls1), .frame_start(fs1)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // n = enabled edges since the last reset release; position index
   // p = (n-1) mod frame size once at least one edge has happened.
   int n = 0;
   bit last_en = 1'b0;

   task automatic model_step(input logic r, input logic e);
      if (r) begin
         n = 0;
         last_en = 1'b0;
      end else begin
         last_en = e;
         if (e) n++;
      end
   endtask

   task automatic check_model(input string tag);
      int p, ex, ey;
      bit eact, ehs, evs, els, efs;
      if (n == 0) begin
         ex = 0; ey = 0; eact = 0; ehs = 0; evs = 0; els = 0; efs = 0;
      end else begin
         p    = (n - 1) % (HT * VT);
         ex   = p % HT;
         ey   = p / HT;
         eact = (ex < 4) && (ey < 3);
         ehs  = (ex >= 5) && (ex <= 6);
         evs  = (ey == 4);
         els  = last_en && (ex == 0);
         efs  = last_en && (p == 0);
      end
      chk($sformatf("%s.x", tag), x0, ex);
      chk($sformatf("%s.y", tag), y0, ey);
      chk($sformatf("%s.active", tag), act0, eact);
      chk($sformatf("%s.hsync", tag), hs0, ehs);
      chk($sformatf("%s.vsync", tag), vs0, evs);
      chk($sformatf("%s.line_start", tag), ls0, els);
      chk($sformatf("%s.frame_start", tag), fs0, efs);
      chk($sformatf("%s.inv.x", tag), x1, ex);
      chk($sformatf("%s.inv.y", tag), y1, ey);
      chk($sformatf("%s.inv.active", tag), act1, eact);
      chk($sformatf("%s.inv.hsync", tag), hs1, !ehs);
      chk($sformatf("%s.inv.vsync", tag), vs1, !evs);
      chk($sformatf("%s.inv.line_start", tag), ls1, els);
      chk($sformatf("%s.inv.frame_start", tag), fs1, efs);
   endtask

   // Drive one clk: inputs change 1 time unit after the rising edge, outputs
   // are sampled 1 time unit after the following rising edge.
   task automatic step(input logic r, input logic e);
      rst = r;
      pix_en = e;
      @(posedge clk);
      #1;
      model_step(r, e);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic r;
      logic e;
      int   ex;
      int   ey;
      logic eact;
      logic ehs;
      logic evs;
      logic els;
      logic efs;
   } vec_t;

   vec_t tbl[13];

   int edge_cnt;
   int fs_edges[$];
   int ls_edges[$];
   bit reached;

   initial begin
      //           r  e  x  y  act hs vs ls fs
      tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 0, 0, 1, 0, 0, 1, 1};
      tbl[3]  = '{0, 1, 1, 0, 1, 0, 0, 0, 0};
      tbl[4]  = '{0, 0, 1, 0, 1, 0, 0, 0, 0};
      tbl[5]  = '{0, 1, 2, 0, 1, 0, 0, 0, 0};
      tbl[6]  = '{0, 1, 3, 0, 1, 0, 0, 0, 0};
      tbl[7]  = '{0, 1, 4, 0, 0, 0, 0, 0, 0};
      tbl[8]  = '{0, 1, 5, 0, 0, 1, 0, 0, 0};
      tbl[9]  = '{0, 0, 5, 0, 0, 1, 0, 0, 0};
      tbl[10] = '{0, 1, 6, 0, 0, 1, 0, 0, 0};
      tbl[11] = '{0, 1, 7, 0, 0, 0, 0, 0, 0};
      tbl[12] = '{0, 1, 0, 1, 1, 0, 0, 1, 0};

      #1;
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].r, tbl[i].e);
         chk($sformatf("tbl%0d.x", i), x0, tbl[i].ex);
         chk($sformatf("tbl%0d.y", i), y0, tbl[i].ey);
         chk($sformatf("tbl%0d.active", i), act0, tbl[i].eact);
         chk($sformatf("tbl%0d.hsync", i), hs0, tbl[i].ehs);
         chk($sformatf("tbl%0d.vsync", i), vs0, tbl[i].evs);
         chk($sformatf("tbl%0d.line_start", i), ls0, tbl[i].els);
         chk($sformatf("tbl%0d.frame_start", i), fs0, tbl[i].efs);
         chk($sformatf("tbl%0d.inv.hsync", i), hs1, !tbl[i].ehs);
         chk($sformatf("tbl%0d.inv.vsync", i), vs1, !tbl[i].evs);
         chk($sformatf("tbl%0d.inv.x", i), x1, tbl[i].ex);
         $display("vec %0d: rst=%0b en=%0b x=%0d y=%0d act=%0b hs=%0b vs=%0b ls=%0b fs=%0b",
                  i, tbl[i].r, tbl[i].e, x0, y0, act0, hs0, vs0, ls0, fs0);
      end

      // Continuous run over two frame boundaries: line and frame periods.
      edge_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b1);
         edge_cnt++;
         check_model("run");
         if (ls0) ls_edges.push_back(edge_cnt);
         if (fs0) fs_edges.push_back(edge_cnt);
      end
      $display("run: %0d line_starts, %0d frame_starts", ls_edges.size(), fs_edges.size());
      chk("run.frame_count", (fs_edges.size() >= 2), 1);
      if (fs_edges.size() >= 2)
         chk("run.frame_period", fs_edges[1] - fs_edges[0], HT * VT);
      for (int i = 1; i < ls_edges.size(); i++)
         chk($sformatf("run.line_period%0d", i), ls_edges[i] - ls_edges[i-1], HT);

      // pix_en on every third clk.
      step(1'b1, 1'b0);
      check_model("third.rst");
      for (int i = 0; i < 90; i++) begin
         step(1'b0, (i % 3) == 0);
         check_model($sformatf("third%0d", i));
         $display("third %0d: en=%0b x=%0d y=%0d ls=%0b fs=%0b", i, pix_en, x0, y0, ls0, fs0);
      end

      // Randomised enable pattern with occasional reset.
      for (int i = 0; i < 400; i++) begin
         logic r, e;
         r = ($urandom_range(0, 99) == 0);
         e = ($urandom_range(0, 3) != 0);
         step(r, e);
         check_model($sformatf("rnd%0d", i));
      end

      // Asynchronous reset in the middle of a line at (6,2).
      step(1'b1, 1'b0);
      reached = 1'b0;
      for (int i = 0; i < 100 && !reached; i++) begin
         step(1'b0, 1'b1);
         check_model("pre_rst");
         if (n == 2 * HT + 6 + 1) reached = 1'b1;
      end
      chk("async.reach_x6y2", reached, 1);
      chk("async.pre.x", x0, 6);
      chk("async.pre.y", y0, 2);
      #3;
      rst = 1'b1;
      #1;
      model_step(1'b1, 1'b0);
      chk("async.x", x0, 0);
      chk("async.y", y0, 0);
      chk("async.active", act0, 0);
      chk("async.hsync", hs0, 0);
      chk("async.vsync", vs0, 0);
      chk("async.line_start", ls0, 0);
      chk("async.frame_start", fs0, 0);
      chk("async.inv.hsync", hs1, 1);
      chk("async.inv.vsync", vs1, 1);
      $display("async reset: x=%0d y=%0d hs=%0b inv_hs=%0b", x0, y0, hs0, hs1);
      step(1'b1, 1'b1);
      check_model("async.hold");
      step(1'b0, 1'b1);
      check_model("async.restart");
      chk("async.restart.frame_start", fs0, 1);
      step(1'b0, 1'b1);
      check_model("async.after");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
